// File: rtl/bcd_countdown_timer.sv
`timescale 1ns/1ps
// Countdown timer over packed-BCD time-of-day (hh:mm:ss.mmm), decremented once per
// millisecond tick from an internal prescaler; flags expiry at 00:00:00.000.
module bcd_countdown_timer #(
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        load_i,
   input  logic [35:0] load_value_i,
   input  logic        start_i,
   input  logic        pause_i,
   input  logic        clear_i,
   output logic [35:0] count_o,
   output logic        running_o,
   output logic        done_o,
   output logic        expired_o,
   output logic        load_err_o
);

   localparam int unsigned CW   = 36;
   localparam int unsigned NDIG = 9;
   localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            done_q, done_d;
   logic            load_err_q, load_err_d;
   logic            tick;
   logic            load_ok;
   logic [CW-1:0]   count_dec;

   // Tens-of-seconds and tens-of-minutes digits wrap at 5; every other digit at 9.
   function automatic logic [3:0] digit_max(input int unsigned idx);
      return (idx == 4 || idx == 6) ? 4'd5 : 4'd9;
   endfunction

   function automatic logic bcd_valid(input logic [CW-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < 7; i++) begin
         if (v[i*4 +: 4] > digit_max(i)) ok = 1'b0;
      end
      if (v[35:32] > 4'd2 || v[31:28] > 4'd9) ok = 1'b0;
      if (v[35:32] == 4'd2 && v[31:28] > 4'd3) ok = 1'b0;
      return ok;
   endfunction

   // Hours use plain 9-wrap on h1, so 20->19 and 10->09 fall out of the same chain.
   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (borrow) begin
            if (r[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = digit_max(i);
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
   assign load_ok   = bcd_valid(load_value_i);
   assign count_dec = bcd_dec(count_q);

   // State, count and prescaler registers.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         presc_q    <= '0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         presc_q    <= presc_d;
         done_q     <= done_d;
         load_err_q <= load_err_d;
      end
   end

   // Next-state: clear > pause > start/load > tick.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      presc_d    = presc_q;
      done_d     = 1'b0;
      load_err_d = 1'b0;

      if (clear_i) begin
         state_d = ST_IDLE;
         count_d = '0;
         presc_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!pause_i) begin
                  if (load_i) begin
                     if (load_ok) count_d    = load_value_i;
                     else         load_err_d = 1'b1;
                  end else if (start_i && count_q != '0) begin
                     state_d = ST_RUN;
                     presc_d = '0;
                  end
               end
            end
            ST_RUN: begin
               if (pause_i) begin
                  state_d = ST_PAUSE;
               end else if (tick) begin
                  count_d = count_dec;
                  presc_d = '0;
                  if (count_dec == '0) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (!pause_i && start_i) state_d = ST_RUN;
            end
            ST_DONE: begin
               if (!pause_i && load_i) begin
                  if (load_ok) begin
                     count_d = load_value_i;
                     state_d = ST_IDLE;
                  end else begin
                     load_err_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign count_o    = count_q;
   assign running_o  = (state_q == ST_RUN);
   assign expired_o  = (state_q == ST_DONE);
   assign done_o     = done_q;
   assign load_err_o = load_err_q;

endmodule
